// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants for the CPU I/O port block.
//   reg_sel_e     - register offsets from BASE_ADDR (TXDATA/STATUS/RXDATA/CTRL)
//   ST_*          - STATUS bit positions
//   CTRL_LOOPBACK - CTRL loopback bit (used only when IO_PORT_LOOPBACK_EN is defined)
package io_port_pkg;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_RXDATA = 2'd2,
    REG_CTRL   = 2'd3
  } reg_sel_e;

  localparam int unsigned ST_TX_FULL   = 0;
  localparam int unsigned ST_TX_EMPTY  = 1;
  localparam int unsigned ST_RX_VALID  = 2;
  localparam int unsigned ST_TX_OVF    = 3;
  localparam int unsigned ST_COUNT_LSB = 4;
  localparam int unsigned ST_COUNT_W   = 4;

  localparam int unsigned CTRL_LOOPBACK = 0;

endpackage

// File: rtl/io_port_unit_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and occupancy count.
// Ports:
//   clk, reset     - clock, synchronous active-high reset (clears storage too)
//   push, wdata    - write request; accepted when not full or when popping the same edge
//   pop            - read request; ignored while empty
//   full, empty    - occupancy flags
//   count          - entries held, 0..DEPTH
//   head           - oldest entry
module sync_fifo
  import io_port_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

  // Storage, pointers (wrap naturally for power-of-two depth) and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/io_port_unit.sv
// io_port_unit: responder for the CPU's 4-bit-addressed I/O bus.
// Decodes BASE_ADDR..BASE_ADDR+3: TXDATA (write -> TX FIFO), STATUS, RXDATA (read pops
// the RX latch once per io_oe assertion), CTRL.
// Optional feature macro: IO_PORT_LOOPBACK_EN (CTRL bit0 routes TX FIFO into the RX latch).
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   io_addr, io_data, io_oe,
//   io_we                      - CPU I/O bus; io_data driven only on an addressed read
//   out_data, out_valid,
//   out_ready                  - TX byte stream (FIFO head) to the external sink
//   in_data, in_valid,
//   in_ready                   - RX byte stream from the external source
module io_port_unit
  import io_port_pkg::*;
#(
  parameter logic [3:0]  BASE_ADDR  = 4'h0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] io_addr,
  inout  wire  [7:0] io_data,
  input  logic       io_oe,
  input  logic       io_we,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          w_hit;
  reg_sel_e      w_sel;
  logic [7:0]    w_wdata;
  logic          w_wr;
  logic          w_rd;
  logic [7:0]    w_rdata;
  logic          w_loop;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_head;
  logic          w_lb_xfer;
  logic          w_ovf_set;
  logic          w_rx_cap;
  logic          w_rx_pop;
  logic          w_rx_rd;

  logic          r_oe_q;
  logic          r_rx_valid;
  logic          r_rx_hold;
  logic [7:0]    r_rx_byte;
  logic          r_tx_ovf;

  // Address decode: only the 4-aligned upper bits select this block.
  assign w_hit   = (io_addr[3:2] == BASE_ADDR[3:2]);
  assign w_sel   = reg_sel_e'(io_addr[1:0]);
  assign w_wdata = io_data;
  assign w_wr    = io_we && w_hit;
  assign w_rd    = io_oe && w_hit;
  assign w_rx_rd = w_rd && (w_sel == REG_RXDATA);

`ifdef IO_PORT_LOOPBACK_EN
  logic r_loop;

  // CTRL loopback bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_loop <= 1'b0;
    end else if (w_wr && (w_sel == REG_CTRL)) begin
      r_loop <= w_wdata[CTRL_LOOPBACK];
    end
  end

  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  // TX FIFO: CPU pushes, sink (or loopback into the RX latch) pops.
  assign w_push    = w_wr && (w_sel == REG_TXDATA);
  assign w_lb_xfer = w_loop && !w_empty && !r_rx_valid;
  assign w_pop     = w_loop ? w_lb_xfer : (out_valid && out_ready);
  assign w_ovf_set = w_push && w_full && !w_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .wdata (w_wdata),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .head  (w_head)
  );

  // RX pop fires on the first cycle of an io_oe assertion only.
  assign w_rx_pop = w_rx_rd && !r_oe_q && r_rx_valid;
  assign w_rx_cap = !w_loop && in_valid && !r_rx_valid;

  // io_oe edge detect, RX latch, read-hold and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_oe_q     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_hold  <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_tx_ovf   <= 1'b0;
    end else begin
      r_oe_q <= io_oe;
      if (w_lb_xfer) begin
        r_rx_byte  <= w_head;
        r_rx_valid <= 1'b1;
      end else if (w_rx_cap) begin
        r_rx_byte  <= in_data;
        r_rx_valid <= 1'b1;
      end else if (w_rx_pop) begin
        r_rx_valid <= 1'b0;
      end
      // Keeps the popped byte visible for the rest of the same read strobe.
      r_rx_hold <= w_rx_pop || (r_rx_hold && w_rx_rd);
      if (w_ovf_set) begin
        r_tx_ovf <= 1'b1;
      end else if (w_wr && (w_sel == REG_STATUS) && w_wdata[ST_TX_OVF]) begin
        r_tx_ovf <= 1'b0;
      end
    end
  end

  // Read data mux.
  always_comb begin
    w_rdata = 8'h00;
    case (w_sel)
      REG_STATUS: begin
        w_rdata[ST_TX_FULL]                   = w_full;
        w_rdata[ST_TX_EMPTY]                  = w_empty;
        w_rdata[ST_RX_VALID]                  = r_rx_valid;
        w_rdata[ST_TX_OVF]                    = r_tx_ovf;
        w_rdata[ST_COUNT_LSB +: ST_COUNT_W]   = ST_COUNT_W'(w_count);
      end
      REG_RXDATA: w_rdata = (r_rx_valid || r_rx_hold) ? r_rx_byte : 8'h00;
`ifdef IO_PORT_LOOPBACK_EN
      REG_CTRL:   w_rdata[CTRL_LOOPBACK] = r_loop;
`endif
      default:    w_rdata = 8'h00;
    endcase
  end

  // Tristate driver.
  assign io_data = w_rd ? w_rdata : 8'hzz;

  assign out_data  = w_head;
  assign out_valid = !w_empty && !w_loop;
  assign in_ready  = !w_loop && !r_rx_valid;

endmodule

// File: tb/tb_io_port_unit.sv
// Directed + randomized bench for io_port_unit with a queue-based reference model.
module tb_io_port_unit;

  localparam int         DEPTH = 8;
  localparam logic [3:0] BASE  = 4'h4;
  localparam logic [3:0] IDLE  = 4'h0;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] io_addr;
  logic       io_oe, io_we;
  logic       cpu_drv;
  logic [7:0] cpu_data;
  wire  [7:0] io_data;
  logic [7:0] out_data;
  logic       out_valid, out_ready;
  logic [7:0] in_data;
  logic       in_valid, in_ready;

  assign io_data = cpu_drv ? cpu_data : 8'hzz;

  io_port_unit #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_data(io_data), .io_oe(io_oe),
    .io_we(io_we), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  byte unsigned q[$];
  bit         m_rxv  = 0;
  bit         m_hold = 0;
  bit         m_ovf  = 0;
  bit         m_oe_q = 0;
  bit         m_loop = 0;
  logic [7:0] m_rx   = 8'h00;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [1:0] off);
    case (off)
      2'd1:    return {4'(q.size()), m_ovf, m_rxv, (q.size() == 0), (q.size() == DEPTH)};
      2'd2:    return (m_rxv || m_hold) ? m_rx : 8'h00;
      2'd3:    return m_loop ? 8'h01 : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // One clock edge: model decisions from pre-edge inputs, applied at the edge.
  task automatic tick();
    bit hit, push, clr, pop_tx, lb, cap, rd_rx, rxpop;
    logic [1:0] off;
    logic [7:0] wd;
    int n;
`ifdef IO_PORT_LOOPBACK_EN
    bit ctrl_wr;
`endif
    hit    = (io_addr[3:2] == BASE[3:2]);
    off    = io_addr[1:0];
    n      = q.size();
    push   = io_we && hit && (off == 2'd0);
    clr    = io_we && hit && (off == 2'd1) && cpu_data[3];
    pop_tx = !m_loop && (n > 0) && out_ready;
    lb     = m_loop && (n > 0) && !m_rxv;
    cap    = !m_loop && in_valid && !m_rxv;
    rd_rx  = io_oe && hit && (off == 2'd2);
    rxpop  = rd_rx && !m_oe_q && m_rxv;
`ifdef IO_PORT_LOOPBACK_EN
    ctrl_wr = io_we && hit && (off == 2'd3);
`endif
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_rxv = 0; m_hold = 0; m_ovf = 0; m_oe_q = 0; m_loop = 0; m_rx = 8'h00;
    end else begin
      if (pop_tx || lb) begin
        wd = q.pop_front();
        if (lb) begin m_rx = wd; m_rxv = 1; end
      end
      if (clr) m_ovf = 0;
      if (push) begin
        if (q.size() < DEPTH) q.push_back(cpu_data);
        else m_ovf = 1;
      end
      if (cap) begin m_rx = in_data; m_rxv = 1; end
      if (rxpop) m_rxv = 0;
      m_hold = rxpop || (m_hold && rd_rx);
`ifdef IO_PORT_LOOPBACK_EN
      if (ctrl_wr) m_loop = cpu_data[0];
`endif
      m_oe_q = io_oe;
    end
    #1;
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    io_addr = BASE | {2'b00, off}; io_we = 1; cpu_drv = 1; cpu_data = d;
    tick();
    io_we = 0; cpu_drv = 0; io_addr = IDLE;
  endtask

  task automatic rd(input logic [1:0] off, input logic [7:0] exp, input string tag);
    io_addr = BASE | {2'b00, off}; io_oe = 1;
    #1;
    chk(tag, io_data, exp);
    tick();
    io_oe = 0; io_addr = IDLE;
    tick();
  endtask

  initial begin
    reset = 1; io_addr = IDLE; io_oe = 0; io_we = 0; cpu_drv = 0; cpu_data = 8'h00;
    out_ready = 0; in_data = 8'h00; in_valid = 0;
    tick(); tick();
    reset = 0;
    #1;

    // Reset state
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in_ready", {7'b0, in_ready}, 8'h01);
    rd(2'd1, 8'h02, "rst_status");
    rd(2'd3, 8'h00, "rst_ctrl");
    // Bus released when not read / not addressed
    cpu_drv = 1; cpu_data = 8'hA5; io_addr = BASE | 4'd1; #1;
    chk("hiz_no_oe", io_data, 8'hA5);
    io_addr = IDLE; io_oe = 1; cpu_data = 8'h5A; #1;
    chk("hiz_miss", io_data, 8'h5A);
    io_oe = 0; cpu_drv = 0; #1;

    // Single byte through TX
    wr(2'd0, 8'h2A);
    rd(2'd1, 8'h10, "tx1_status");
    out_ready = 1; #1;
    chk("tx1_valid", {7'b0, out_valid}, 8'h01);
    chk("tx1_data", out_data, 8'h2A);
    tick();
    out_ready = 0; #1;
    chk("tx1_valid_after", {7'b0, out_valid}, 8'h00);
    rd(2'd1, 8'h02, "tx1_status_empty");

    // Overflow
    for (int i = 1; i <= 9; i++) wr(2'd0, 8'(i));
    rd(2'd1, 8'h89, "ovf_status");
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("ovf_drain", out_data, 8'(i));
      tick();
    end
    out_ready = 0; #1;
    rd(2'd1, 8'h0A, "ovf_sticky");
    wr(2'd1, 8'h08);
    rd(2'd1, 8'h02, "ovf_cleared");

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) wr(2'd0, 8'(8'h11 + i));
    out_ready = 1;
    wr(2'd0, 8'h55);
    out_ready = 0; #1;
    rd(2'd1, 8'h81, "fullpp_status");
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fullpp_drain", out_data, (i == 7) ? 8'h55 : 8'(8'h12 + i));
      tick();
    end
    out_ready = 0; #1;

    // RX capture and single pop per read strobe
    in_data = 8'hC3; in_valid = 1;
    tick();
    in_valid = 0; #1;
    chk("rx_in_ready", {7'b0, in_ready}, 8'h00);
    rd(2'd1, 8'h06, "rx_status");
    io_addr = BASE | 4'd2; io_oe = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rx_multi_read", io_data, 8'hC3);
      tick();
    end
    io_oe = 0; io_addr = IDLE; tick();
    chk("rx_in_ready_after", {7'b0, in_ready}, 8'h01);
    rd(2'd2, 8'h00, "rx_second_read");

    // Reset mid-transfer
    for (int i = 0; i < 4; i++) wr(2'd0, 8'(8'hA0 + i));
    in_data = 8'h3C; in_valid = 1; tick(); in_valid = 0;
    reset = 1; tick(); reset = 0; #1;
    chk("rst2_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst2_in_ready", {7'b0, in_ready}, 8'h01);
    rd(2'd1, 8'h02, "rst2_status");

    // CTRL / loopback
    wr(2'd3, 8'h01);
`ifdef IO_PORT_LOOPBACK_EN
    rd(2'd3, 8'h01, "ctrl_readback");
    wr(2'd0, 8'h7E);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lb_out_valid", {7'b0, out_valid}, 8'h00);
      chk("lb_in_ready", {7'b0, in_ready}, 8'h00);
      tick();
    end
    rd(2'd2, 8'h7E, "lb_rxdata");
    wr(2'd3, 8'h00);
`else
    rd(2'd3, 8'h00, "ctrl_readback");
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      int op;
      op = int'($urandom_range(0, 7));
      out_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      io_we = 0; io_oe = 0; cpu_drv = 0; io_addr = IDLE;
      case (op)
        0, 1, 2: begin io_addr = BASE; io_we = 1; cpu_drv = 1; cpu_data = 8'($urandom); end
        3:       begin io_addr = BASE | 4'd1; io_oe = 1; end
        4, 5:    begin io_addr = BASE | 4'd2; io_oe = 1; end
        6:       begin io_addr = BASE | 4'd1; io_we = 1; cpu_drv = 1; cpu_data = 8'($urandom); end
        default: begin io_addr = IDLE; io_we = 1; cpu_drv = 1; cpu_data = 8'($urandom); end
      endcase
      #1;
      chk("rnd_out_valid", {7'b0, out_valid}, {7'b0, (q.size() > 0) && !m_loop});
      chk("rnd_in_ready", {7'b0, in_ready}, {7'b0, !m_loop && !m_rxv});
      if (q.size() > 0) chk("rnd_out_data", out_data, q[0]);
      if (io_oe) chk("rnd_read", io_data, exp_rd(io_addr[1:0]));
      tick();
    end
    io_we = 0; io_oe = 0; cpu_drv = 0; io_addr = IDLE;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_port_unit.md
# io_port_unit

CPU-side peripheral that answers the computer's 4-bit-addressed I/O bus (io_addr / io_data / io_oe / io_we). It is the responder for the CPU's I/O instructions.
- Write side: CPU writes are buffered in a transmit FIFO and drained to an external byte sink over valid/ready.
- Read side: bytes from an external source are held in a receive latch until the CPU reads them.
- Instantiation: inside computer, alongside memory1, replacing direct testbench snooping of io_we.

## Interface
- BASE_ADDR, 4'h0: I/O base; must be 4-aligned; block decodes BASE_ADDR..BASE_ADDR+3.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, 2..8.
- clk  input  1: single clock, rising edge.
- reset  input  1: synchronous, active-high.
- io_addr  input  4: CPU I/O address.
- io_data  inout  8: CPU I/O data. Driven only while io_oe=1 and io_addr hits; high-Z otherwise.
- io_oe  input  1: CPU read strobe.
- io_we  input  1: CPU write strobe.
- out_data  output  8: TX FIFO head byte.
- out_valid  output  1: TX FIFO not empty.
- out_ready  input  1: sink accepts.
- in_data  input  8: source byte.
- in_valid  input  1: source byte valid.
- in_ready  output  1: RX latch empty.

## Operation
- Register map (offset from BASE_ADDR):
  - 0 TXDATA: write only; reads 0.
  - 1 STATUS
  - 2 RXDATA: read only.
  - 3 CTRL: see Configuration.
- TXDATA write pushes the byte into the TX FIFO.
  - Every clock edge with io_we=1 and an address hit is one write; a multi-cycle io_we gives multiple pushes.
  - Push while full and no same-cycle pop: byte dropped, tx_overflow set (sticky).
- STATUS read:
  - bit0 tx_full
  - bit1 tx_empty
  - bit2 rx_valid
  - bit3 tx_overflow
  - bits7:4 tx_count (0..FIFO_DEPTH)
- STATUS write: a 1 in bit3 clears tx_overflow; other bits ignored.
- RXDATA read returns the rx byte (0x00 if rx_valid=0). Reading clears rx_valid.
  - The clear happens on the first edge of an io_oe assertion only, detected via registered io_oe_q.
  - A multi-cycle io_oe pops once.
- RX capture: in_valid && in_ready at an edge loads the rx byte and sets rx_valid. in_ready = !rx_valid.
- TX drain: out_valid && out_ready at an edge pops the FIFO head.
- io_we and io_oe both high in the same cycle: the write is processed; read data is still driven.

## Timing
- Reset values:
  - FIFO empty, count 0.
  - out_valid 0, out_data 0x00.
  - in_ready 1, rx_valid 0, tx_overflow 0, CTRL 0.
  - io_data high-Z.
- Read data path is combinational from io_addr/io_oe to io_data; valid in the same cycle.
- TX latency: a push at edge N gives out_valid=1 and out_data=byte in cycle N+1.
- RX latency:
  - Capture at edge M gives rx_valid=1 and in_ready=0 from cycle M+1.
  - A CPU pop at edge K gives in_ready=1 from cycle K+1. A new capture is possible at edge K+1.
- Full FIFO with push and pop at the same edge: both accepted, count unchanged, no overflow.
- Empty FIFO with push and no pop: count becomes 1. A pop cannot occur while empty.
- Pointers wrap modulo FIFO_DEPTH. Count is clog2(FIFO_DEPTH)+1 bits wide.
- Reset asserted mid-transfer discards FIFO contents and the rx byte at that edge; the sink sees out_valid fall the next cycle.

## Configuration
- Macro: IO_PORT_LOOPBACK_EN.
- Defined:
  - CTRL bit0 is loopback, R/W, reset 0.
  - With loopback=1, the FIFO head feeds the RX latch internally: pop when !rx_valid. out_valid is held 0; in_valid/in_data are ignored and in_ready is held 0.
- Undefined:
  - CTRL reads 0x00; writes are ignored.
  - The external out/in paths are always used.

## Structure
- Package io_port_pkg:
  - offset constants TXDATA/STATUS/RXDATA/CTRL
  - STATUS bit-position constants
  - CTRL loopback bit constant
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop/full/empty/count/head.
- Top-level io_port_unit contains:
  - address decode
  - io_oe edge detect
  - RX latch
  - overflow flag
  - tristate driver

## Test plan
- Write 0x2A to TXDATA with out_ready=0 → STATUS reads 0x10. Raise out_ready → out_data=0x2A for one cycle, then STATUS reads 0x02.
- 9 writes 0x01..0x09 with out_ready=0, FIFO_DEPTH=8 → STATUS 0x89. Drain yields 0x01..0x08. Writing 0x08 to STATUS then reads 0x02.
- Full FIFO, out_ready=1, simultaneous write 0x55 → no overflow. 0x55 emerges 8th.
- in_data=0xC3, in_valid=1 → in_ready=0 next cycle and STATUS bit2=1. A 3-cycle io_oe at RXDATA returns 0xC3 throughout and pops once. A second read returns 0x00.
- Reset asserted with 4 bytes queued and rx_valid=1 → next cycle out_valid=0, in_ready=1, STATUS=0x02.
- With IO_PORT_LOOPBACK_EN: set CTRL=0x01, write 0x7E → RXDATA reads 0x7E and out_valid stays 0.
